// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that shares one bank of JK flip-flops among NREQ requesters,
// with an optional ownership lock and a watchdog that frees an abandoned lock.
module jk_bank_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int IDXW     = 3,
    parameter int LOCK_TMO = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_j,
    input  logic [NREQ-1:0]        req_k,
    input  logic [NREQ*IDXW-1:0]   req_idx,
    input  logic [NREQ-1:0]        req_lock,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       qbar,
    output logic [NREQ-1:0]        done,
    output logic                   err,
    output logic                   lock_timeout,
    output logic [NREQ-1:0]        owner
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = 1 << IDXW;
    localparam logic [HW-1:0] IN_MASK = HW'({WIDTH{1'b1}});

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NREQ) s = s - NREQ;
        else           s = s;
        return s[PW-1:0];
    endfunction

    function automatic logic jk_next(input logic cur, input logic j, input logic k);
        logic nxt;
        case ({j, k})
            2'b00:   nxt = cur;
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            2'b11:   nxt = ~cur;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    state_t            r_state;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_own_idx;
    logic [NREQ-1:0]   r_owner;
    logic [7:0]        r_cnt;
    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  r_qbar;
    logic [NREQ-1:0]   r_done;
    logic              r_err;
    logic              r_tmo;

    logic              w_found;
    logic [PW-1:0]     w_gidx;
    logic [NREQ-1:0]   w_gnt;
    logic              w_locked;
    logic [PW-1:0]     w_sel;
    logic [NREQ-1:0]   w_ready;
    logic              w_xfer;
    logic              w_j;
    logic              w_k;
    logic              w_lock;
    logic [IDXW-1:0]   w_idx;
    logic [HW-1:0]     w_hot;
    logic              w_oob;
    logic [WIDTH-1:0]  w_q_next;

    // Round-robin scan: first valid requester at or after the pointer, with wrap
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[wrap_add(r_ptr, i)]) begin
                w_gidx  = wrap_add(r_ptr, i);
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
        if (w_found) w_gnt = NREQ'(1'b1) << w_gidx;
        else         w_gnt = '0;
    end

    // Handshake and next bank value; a locked bank only listens to its owner
    always_comb begin
        w_locked = (r_state == ST_LOCKED);
        w_sel    = w_locked ? r_own_idx : w_gidx;
        if (!resetn)       w_ready = '0;
        else if (w_locked) w_ready = req_valid & r_owner;
        else               w_ready = w_gnt;
        w_xfer   = |w_ready;
        w_j      = req_j[w_sel];
        w_k      = req_k[w_sel];
        w_lock   = req_lock[w_sel];
        w_idx    = req_idx[int'(w_sel)*IDXW +: IDXW];
        w_hot    = HW'(1'b1) << w_idx;
        w_oob    = ~|(w_hot & IN_MASK);
        w_q_next = r_q;
        for (int b = 0; b < WIDTH; b++) begin
            if (w_hot[b]) w_q_next[b] = jk_next(r_q[b], w_j, w_k);
            else          w_q_next[b] = r_q[b];
        end
    end

    // Arbitration FSM, watchdog and registered bank/pulse outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_own_idx <= '0;
            r_owner   <= '0;
            r_cnt     <= 8'd0;
            r_q       <= '0;
            r_qbar    <= '1;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_tmo     <= 1'b0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            r_tmo  <= 1'b0;
            if (w_xfer) begin
                r_done <= w_ready;
                r_err  <= w_oob;
                r_q    <= w_q_next;
                r_qbar <= ~w_q_next;
                r_ptr  <= wrap_add(w_sel, 1);
                r_cnt  <= 8'd0;
                if (w_lock) begin
                    r_state   <= ST_LOCKED;
                    r_own_idx <= w_sel;
                    r_owner   <= w_ready;
                end else begin
                    r_state   <= ST_IDLE;
                    r_owner   <= '0;
                end
            end else if (w_locked) begin
                // Abandoned lock: release at the edge where the idle count reaches LOCK_TMO
                if (r_cnt == 8'(LOCK_TMO - 1)) begin
                    r_state <= ST_IDLE;
                    r_owner <= '0;
                    r_cnt   <= 8'd0;
                    r_tmo   <= 1'b1;
                    r_ptr   <= wrap_add(r_own_idx, 1);
                end else begin
                    r_cnt   <= r_cnt + 8'd1;
                end
            end else begin
                r_cnt <= 8'd0;
            end
        end
    end

    assign req_ready    = w_ready;
    assign q            = r_q;
    assign qbar         = r_qbar;
    assign done         = r_done;
    assign err          = r_err;
    assign lock_timeout = r_tmo;
    assign owner        = r_owner;

endmodule
